// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry, writeback requester indices and the
// round-robin pointer helper used by the writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_AW = 3;
    localparam int REG_DW = 8;
    localparam int REG_N  = 8;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_HOST = 2;

    typedef enum logic [1:0] {
        WB_SRC_ALU  = 2'd0,
        WB_SRC_LOAD = 2'd1,
        WB_SRC_HOST = 2'd2
    } wb_src_e;

    // Pointer value after granting index idx: the slot just past the winner, wrapping at n.
    function automatic logic [1:0] rr_next(input logic [1:0] idx, input int n);
        logic [1:0] nxt;
        if (int'(idx) >= n - 1) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr (ascending, wrapping). The pointer itself is kept by the parent.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found_s;

    // Walk the requests from ptr upwards and grant the first one found.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (enable && !found_s && req[(int'(ptr) + k) % N]) begin
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx     = PW'((int'(ptr) + k) % N);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 8x8 register file: round-robin shares the single
// write port between requesters, registers the winning write towards the
// register file and tracks outstanding destination writes in a busy scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = REG_DW,
    parameter int AW   = REG_AW,
    parameter int NREG = REG_N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              hold,
    input  logic              claim_valid,
    input  logic [AW-1:0]     claim_addr,
    output logic              rf_regwrite,
    output logic [AW-1:0]     rf_writeadd,
    output logic [DW-1:0]     rf_writedata,
    output logic [1:0]        rf_grant_id,
    output logic [NREG-1:0]   busy,
    output logic              err_overclaim
);

    localparam int PW = 2;

    logic [PW-1:0]   ptr_r;
    logic [NREQ-1:0] gnt_s;
    logic [PW-1:0]   grant_idx_s;
    logic            arb_en_s;
    logic            accept_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;

    logic            regwrite_r;
    logic [AW-1:0]   writeadd_r;
    logic [DW-1:0]   writedata_r;
    logic [1:0]      grant_id_r;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic            err_r;
    logic            overclaim_s;

    // Arbitration is frozen by hold and suppressed entirely while in reset.
    assign arb_en_s = rst_n & ~hold;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_r),
        .enable (arb_en_s),
        .gnt    (gnt_s),
        .idx    (grant_idx_s)
    );

    assign req_ready   = gnt_s;
    assign accept_s    = |(req_valid & gnt_s);
    assign sel_addr_s  = req_addr[int'(grant_idx_s)*AW +: AW];
    assign sel_data_s  = req_data[int'(grant_idx_s)*DW +: DW];

    // Registered write towards the register file plus the round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwrite_r  <= 1'b0;
            writeadd_r  <= '0;
            writedata_r <= '0;
            grant_id_r  <= 2'd0;
            ptr_r       <= '0;
        end else begin
            regwrite_r <= accept_s;
            if (accept_s) begin
                writeadd_r  <= sel_addr_s;
                writedata_r <= sel_data_s;
                grant_id_r  <= grant_idx_s;
                ptr_r       <= rr_next(grant_idx_s, NREQ);
            end else begin
                writeadd_r  <= writeadd_r;
                writedata_r <= writedata_r;
                grant_id_r  <= grant_id_r;
                ptr_r       <= ptr_r;
            end
        end
    end

    // Next scoreboard state: the current rf write retires its bit, a new claim sets it (claim wins).
    always_comb begin
        busy_nxt_s = busy_r;
        if (regwrite_r) begin
            busy_nxt_s[writeadd_r] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (claim_valid) begin
            busy_nxt_s[claim_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
    end

    // A claim on a register that is still busy and not retiring this cycle is a double writer.
    assign overclaim_s = claim_valid & busy_r[claim_addr] &
                         ~(regwrite_r && (writeadd_r == claim_addr));

    // Scoreboard and sticky overclaim flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= '0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            err_r  <= err_r | overclaim_s;
        end
    end

    assign rf_regwrite   = regwrite_r;
    assign rf_writeadd   = writeadd_r;
    assign rf_writedata  = writedata_r;
    assign rf_grant_id   = grant_id_r;
    assign busy          = busy_r;
    assign err_overclaim = err_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin order,
// hold, back-to-back same-address writes, scoreboard and overclaim behaviour.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [8:0]  req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        hold;
    logic        claim_valid;
    logic [2:0]  claim_addr;
    logic        rf_regwrite;
    logic [2:0]  rf_writeadd;
    logic [7:0]  rf_writedata;
    logic [1:0]  rf_grant_id;
    logic [7:0]  busy;
    logic        err_overclaim;

    int tests;
    int fails;

    regfile_wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .hold          (hold),
        .claim_valid   (claim_valid),
        .claim_addr    (claim_addr),
        .rf_regwrite   (rf_regwrite),
        .rf_writeadd   (rf_writeadd),
        .rf_writedata  (rf_writedata),
        .rf_grant_id   (rf_grant_id),
        .busy          (busy),
        .err_overclaim (err_overclaim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_valid   = 3'b000;
        hold        = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        hold        = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = 3'd0;
        req_addr    = 9'h1FF;
        req_data    = 24'hFFFFFF;
        req_valid   = 3'b111;
        tick();
        tick();
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got %b want %b", req_ready, 3'b000); end
        tests++; if (rf_regwrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %b want 0", rf_regwrite); end
        tests++; if (rf_writeadd !== 3'd0 || rf_writedata !== 8'h00 || rf_grant_id !== 2'd0) begin
            fails++; $display("FAIL reset_outs got %h/%h/%h want 0/00/0", rf_writeadd, rf_writedata, rf_grant_id); end
        tests++; if (busy !== 8'h00) begin fails++; $display("FAIL reset_busy got %h want 00", busy); end
        tests++; if (err_overclaim !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_overclaim); end
        req_valid = 3'b000;
        rst_n     = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        req_addr[2:0]  = 3'd3;
        req_data[7:0]  = 8'hA5;
        req_valid      = 3'b001;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL single_ready got %b want 001", req_ready); end
        tick();
        req_valid = 3'b000;
        tests++; if (rf_regwrite !== 1'b1 || rf_writeadd !== 3'd3 || rf_writedata !== 8'hA5 || rf_grant_id !== 2'd0) begin
            fails++; $display("FAIL single_write got %b/%h/%h/%h want 1/3/a5/0", rf_regwrite, rf_writeadd, rf_writedata, rf_grant_id); end
        tick();
        tests++; if (rf_regwrite !== 1'b0) begin fails++; $display("FAIL single_idle got %b want 0", rf_regwrite); end
        tests++; if (rf_writeadd !== 3'd3 || rf_writedata !== 8'hA5) begin
            fails++; $display("FAIL single_keep got %h/%h want 3/a5", rf_writeadd, rf_writedata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_addr;
        logic [7:0] exp_data;
        logic [2:0] exp_ready;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_addr[i*3 +: 3] = 3'(i + 4);
            req_data[i*8 +: 8] = 8'(8'h10 + i);
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_ready = 3'b001 << (k % 3);
            exp_addr  = 3'((k % 3) + 4);
            exp_data  = 8'(8'h10 + (k % 3));
            #1;
            tests++; if (req_ready !== exp_ready) begin fails++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_ready); end
            tick();
            tests++; if (rf_regwrite !== 1'b1 || rf_grant_id !== 2'(k % 3) || rf_writeadd !== exp_addr || rf_writedata !== exp_data) begin
                fails++; $display("FAIL rr_write[%0d] got %b/%0d/%h/%h want 1/%0d/%h/%h", k, rf_regwrite, rf_grant_id,
                                  rf_writeadd, rf_writedata, k % 3, exp_addr, exp_data); end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        req_addr[5:3]  = 3'd1;
        req_data[15:8] = 8'h5C;
        hold           = 1'b1;
        req_valid      = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL hold_ready[%0d] got %b want 000", k, req_ready); end
            tick();
            tests++; if (rf_regwrite !== 1'b0) begin fails++; $display("FAIL hold_regwrite[%0d] got %b want 0", k, rf_regwrite); end
        end
        hold = 1'b0;
        #1;
        tests++; if (req_ready !== 3'b010) begin fails++; $display("FAIL hold_release got %b want 010", req_ready); end
        tick();
        req_valid = 3'b000;
        tests++; if (rf_regwrite !== 1'b1 || rf_grant_id !== 2'd1 || rf_writedata !== 8'h5C) begin
            fails++; $display("FAIL hold_write got %b/%0d/%h want 1/1/5c", rf_regwrite, rf_grant_id, rf_writedata); end
        // ptr now points at requester 2, which is idle: search must wrap to requester 0.
        req_valid = 3'b011;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL hold_wrap got %b want 001", req_ready); end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_addr[2:0]  = 3'd6;
        req_addr[5:3]  = 3'd6;
        req_data[7:0]  = 8'h11;
        req_data[15:8] = 8'h22;
        req_valid      = 3'b011;
        tick();
        tests++; if (rf_grant_id !== 2'd0 || rf_writeadd !== 3'd6 || rf_writedata !== 8'h11) begin
            fails++; $display("FAIL b2b_first got %0d/%h/%h want 0/6/11", rf_grant_id, rf_writeadd, rf_writedata); end
        tick();
        tests++; if (rf_regwrite !== 1'b1 || rf_grant_id !== 2'd1 || rf_writeadd !== 3'd6 || rf_writedata !== 8'h22) begin
            fails++; $display("FAIL b2b_second got %b/%0d/%h/%h want 1/1/6/22", rf_regwrite, rf_grant_id, rf_writeadd, rf_writedata); end
        req_addr[8:6]   = 3'd7;
        req_data[23:16] = 8'hC3;
        req_valid       = 3'b100;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++; if (req_ready !== 3'b100) begin fails++; $display("FAIL solo_ready[%0d] got %b want 100", k, req_ready); end
            tick();
            tests++; if (rf_regwrite !== 1'b1 || rf_grant_id !== 2'd2 || rf_writedata !== 8'hC3) begin
                fails++; $display("FAIL solo_write[%0d] got %b/%0d/%h want 1/2/c3", k, rf_regwrite, rf_grant_id, rf_writedata); end
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        claim_valid = 1'b1;
        claim_addr  = 3'd5;
        tick();
        claim_valid = 1'b0;
        tests++; if (busy !== 8'h20) begin fails++; $display("FAIL sb_set got %h want 20", busy); end
        tick();
        req_addr[5:3]  = 3'd5;
        req_data[15:8] = 8'h77;
        req_valid      = 3'b010;
        tick();
        req_valid = 3'b000;
        tests++; if (busy[5] !== 1'b1 || rf_regwrite !== 1'b1) begin fails++; $display("FAIL sb_pending got %b/%b want 1/1", busy[5], rf_regwrite); end
        tick();
        tests++; if (busy !== 8'h00) begin fails++; $display("FAIL sb_clear got %h want 00", busy); end
        // Claim r5, write it, and re-claim on the edge that retires the write.
        claim_valid = 1'b1;
        claim_addr  = 3'd5;
        tick();
        claim_valid    = 1'b0;
        req_data[15:8] = 8'h33;
        req_valid      = 3'b010;
        tick();
        req_valid   = 3'b000;
        claim_valid = 1'b1;
        claim_addr  = 3'd5;
        tick();
        claim_valid = 1'b0;
        tests++; if (busy[5] !== 1'b1) begin fails++; $display("FAIL sb_setwins got %b want 1", busy[5]); end
        tests++; if (err_overclaim !== 1'b0) begin fails++; $display("FAIL sb_noerr got %b want 0", err_overclaim); end
    endtask

    task automatic test_overclaim();
        do_reset();
        claim_valid = 1'b1;
        claim_addr  = 3'd2;
        tick();
        tests++; if (err_overclaim !== 1'b0 || busy !== 8'h04) begin
            fails++; $display("FAIL oc_first got %b/%h want 0/04", err_overclaim, busy); end
        tick();
        claim_valid = 1'b0;
        tests++; if (err_overclaim !== 1'b1) begin fails++; $display("FAIL oc_second got %b want 1", err_overclaim); end
        tick();
        tick();
        tests++; if (err_overclaim !== 1'b1) begin fails++; $display("FAIL oc_sticky got %b want 1", err_overclaim); end
        // Reset asserted while a grant is on offer.
        req_data[7:0] = 8'h9E;
        req_valid     = 3'b001;
        #1;
        tests++; if (req_ready !== 3'b001) begin fails++; $display("FAIL rstgrant_pre got %b want 001", req_ready); end
        rst_n = 1'b0;
        #1;
        tests++; if (req_ready !== 3'b000) begin fails++; $display("FAIL rstgrant_ready got %b want 000", req_ready); end
        tick();
        req_valid = 3'b000;
        tests++; if (rf_regwrite !== 1'b0 || err_overclaim !== 1'b0 || busy !== 8'h00) begin
            fails++; $display("FAIL rstgrant_after got %b/%b/%h want 0/0/00", rf_regwrite, err_overclaim, busy); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_n       = 1'b0;
        req_valid   = 3'b000;
        req_addr    = 9'd0;
        req_data    = 24'd0;
        hold        = 1'b0;
        claim_valid = 1'b0;
        claim_addr  = 3'd0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_hold();
        test_back_to_back();
        test_scoreboard();
        test_overclaim();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
